core_pipe_stage: RTL
====================

CORE_PIPE_STAGE -- requirements
Module: core_pipe_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits; legal range 1..256.
REQ-002 Parameter NOP_DATA, default {DATA_WIDTH{1'b0}}, payload shown on out_data whenever out_valid=0 (bubble).
REQ-003 Parameter HOLD_WIDTH, default 3, width of hold_flag_in.
REQ-004 Parameter HOLD_LEVEL, default 2, stage stalls when hold_flag_in >= HOLD_LEVEL (unsigned compare).
REQ-005 Port clk  input  1  rising-edge clock; single clock domain.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port hold_flag_in  input  HOLD_WIDTH  pipeline hold level from core_ctrl.
REQ-008 Port flush_in  input  1  discard all held entries.
REQ-009 Port in_valid  input  1  upstream payload valid.
REQ-010 Port in_ready  output  1  stage accepts payload this cycle.
REQ-011 Port in_data  input  DATA_WIDTH  upstream payload.
REQ-012 Port out_valid  output  1  downstream payload valid.
REQ-013 Port out_ready  input  1  downstream accepts payload.
REQ-014 Port out_data  output  DATA_WIDTH  downstream payload.
REQ-015 Port stall_cnt_out  output  16  saturating count of hold cycles.

Function
REQ-016 hold SHALL equal (hold_flag_in >= HOLD_LEVEL), combinational.
REQ-017 Upstream transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; downstream transfer with out_valid=1 and out_ready=1.
REQ-018 Main entry (main_v, main_d) SHALL drive out_valid = main_v & ~hold; out_data = main_d when out_valid=1, else NOP_DATA.
REQ-019 While hold=1: in_ready=0, out_valid=0, all entries retained unchanged; no transfer on either side.
REQ-020 Latency: payload accepted at edge N SHALL appear on out_data in cycle N+1 when no hold and the stage was empty.
REQ-021 Order SHALL be preserved; no payload duplicated or lost except by flush_in or rst.
REQ-022 flush_in=1 SHALL clear all valid bits at the edge, overriding hold and any simultaneous upstream/downstream transfer; a payload offered in that cycle is dropped; out_valid=0 the next cycle.
REQ-023 While flush_in=1, in_ready SHALL still follow REQ-019/REQ-029/REQ-030; accepted data is discarded.
REQ-024 stall_cnt_out SHALL increment by 1 each cycle hold=1, saturate at 16'hFFFF, and is cleared only by rst.
REQ-025 Full-throughput streaming (in_valid=out_ready=1, no hold) SHALL sustain one transfer per cycle in both configurations.

Reset
REQ-026 rst=1 at an edge SHALL clear main_v and skid_v, load main_d and skid_d with NOP_DATA, clear stall_cnt_out to 0.
REQ-027 After reset: out_valid=0, out_data=NOP_DATA, stall_cnt_out=0, in_ready=1 if hold=0.
REQ-028 rst SHALL override flush_in, hold and any transfer; reset mid-stream discards all entries.

Configuration
REQ-029 Macro CORE_PIPE_SKID_EN defined: a second skid entry (skid_v, skid_d) is built; in_ready = ~hold & ~skid_v, with skid_v a flop, so in_ready has no combinational path from out_ready; a payload accepted while main is full and not draining goes to skid; when main drains, skid moves to main at the same edge; skid_v=1 never coexists with main_v=0.
REQ-030 Macro CORE_PIPE_SKID_EN undefined: no skid entry; in_ready = ~hold & (~main_v | out_ready), combinational from out_ready; capacity one entry.

Verification
REQ-031 Reset: rst=1 two cycles, in_valid=1 in_data=32'h1234 -> out_valid=0, out_data=32'h0, stall_cnt_out=0 after release.
REQ-032 Stream: in_data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later, one per cycle, in_ready stays 1.
REQ-033 Backpressure (skid on): stream 5,6,7, out_ready=0 from cycle after 5 accepted -> in_ready falls after 6 accepted, 7 held upstream; out_ready=1 -> 5,6,7 delivered in order, no loss.
REQ-034 Hold: hold_flag_in=3 (HOLD_LEVEL=2) for 4 cycles with entry 32'hA -> out_valid=0, out_data=NOP_DATA, in_ready=0, stall_cnt_out=4; hold_flag_in=1 -> 32'hA emitted next cycle.
REQ-035 Flush: flush_in=1 with hold_flag_in=3, main and skid full, in_valid=1 in_data=32'hB -> next cycle out_valid=0, 32'hB never emitted.
REQ-036 Saturation: hold held 70000 cycles -> stall_cnt_out=16'hFFFF and remains there.

Source files
------------

// File: rtl/core_pipe_stage.sv
// core_pipe_stage: valid/ready pipeline register with hold, flush and a saturating stall counter.
// Define CORE_PIPE_SKID_EN to add a skid entry so in_ready is registered rather than derived from out_ready.
module core_pipe_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_DATA   = {DATA_WIDTH{1'b0}},
    parameter int unsigned           HOLD_WIDTH = 3,
    parameter int unsigned           HOLD_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HOLD_WIDTH-1:0] hold_flag_in,
    input  logic                  flush_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [15:0]           stall_cnt_out
);

    logic                  hold;
    logic                  in_fire;
    logic                  out_fire;
    logic                  main_v;
    logic [DATA_WIDTH-1:0] main_d;

    assign hold      = (32'(hold_flag_in) >= HOLD_LEVEL);
    assign out_valid = main_v & ~hold;
    assign out_data  = out_valid ? main_d : NOP_DATA;
    assign out_fire  = out_valid & out_ready;
    assign in_fire   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_out <= 16'h0000;
        end else if (hold && (stall_cnt_out != 16'hFFFF)) begin
            stall_cnt_out <= stall_cnt_out + 16'h0001;
        end
    end

`ifdef CORE_PIPE_SKID_EN
    logic                  skid_v;
    logic [DATA_WIDTH-1:0] skid_d;

    assign in_ready = ~hold & ~skid_v;

    // Skid only fills while main is stalled downstream; it refills main as soon as main drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v <= 1'b0;
            main_d <= NOP_DATA;
            skid_v <= 1'b0;
            skid_d <= NOP_DATA;
        end else if (flush_in) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (out_fire) begin
            if (skid_v) begin
                main_d <= skid_d;
                skid_v <= 1'b0;
            end else if (in_fire) begin
                main_d <= in_data;
            end else begin
                main_v <= 1'b0;
            end
        end else if (in_fire) begin
            if (main_v) begin
                skid_v <= 1'b1;
                skid_d <= in_data;
            end else begin
                main_v <= 1'b1;
                main_d <= in_data;
            end
        end
    end

    a_skid_needs_main: assert property (@(posedge clk) disable iff (rst) skid_v |-> main_v);
`else
    assign in_ready = ~hold & (~main_v | out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v <= 1'b0;
            main_d <= NOP_DATA;
        end else if (flush_in) begin
            main_v <= 1'b0;
        end else if (in_fire) begin
            main_v <= 1'b1;
            main_d <= in_data;
        end else if (out_fire) begin
            main_v <= 1'b0;
        end
    end
`endif

endmodule
